rtype_issue_wb: RTL and testbench

Sequencing stage wrapped around the two-phase ALU. It accepts one MIPS R-type instruction word per handshake and reads `rs`/`rt` from an internal 32×32 register file. It presents the operands and `funct` to the ALU, holds them stable long enough to cover either ALU phase alignment, and then captures the result. The result is written back to `rd`, with `$zero`, overflow and illegal-instruction rules applied. Together with the ALU it forms a complete single-issue R-type datapath.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/regfile_2r1w.sv | 27 ++
 rtl/rtype_issue_wb.sv | 106 ++++++++++
 tb/tb_rtype_issue_wb.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared R-type encodings, instruction field positions and the
// issue/writeback sequencer state type.
package mips_pkg;
    localparam logic [5:0] FUNCT_ADD    = 6'b100000;
    localparam logic [5:0] FUNCT_SUB    = 6'b100010;
    localparam logic [5:0] FUNCT_AND    = 6'b100100;
    localparam logic [5:0] FUNCT_OR     = 6'b100101;
    localparam logic [5:0] FUNCT_SLT    = 6'b101010;
    localparam logic [5:0] FUNCT_NOP    = 6'b000000;
    localparam logic [5:0] OPCODE_RTYPE = 6'b000000;
    localparam int OP_LSB = 26;
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int RD_LSB = 11;
    localparam int FN_LSB = 0;
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_HOLD, ST_WB} state_t;
    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        return op == OPCODE_RTYPE &&
               (fn == FUNCT_ADD || fn == FUNCT_SUB || fn == FUNCT_AND ||
                fn == FUNCT_OR  || fn == FUNCT_SLT);
    endfunction
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 32x32 register file, two operand read ports plus a debug port,
// one synchronous write port; index 0 is hardwired to zero.
module regfile_2r1w (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_ra,
    input  logic [4:0]  i_rb,
    input  logic [4:0]  i_rdbg,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic [31:0] o_dbg
);
    logic [31:0] r_mem [32];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) r_mem[i] <= '0;
        end else if (i_we && i_waddr != 5'd0) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end
    assign o_a   = (i_ra   == 5'd0) ? '0 : r_mem[i_ra];
    assign o_b   = (i_rb   == 5'd0) ? '0 : r_mem[i_rb];
    assign o_dbg = (i_rdbg == 5'd0) ? '0 : r_mem[i_rdbg];
endmodule

// File: rtl/rtype_issue_wb.sv
// rtype_issue_wb: single-issue R-type sequencer around the two-phase ALU;
// decodes, holds ALU operands for HOLD_CYCLES edges, then retires to the regfile.
module rtype_issue_wb
    import mips_pkg::*;
#(
    parameter int HOLD_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [5:0]  alu_funct,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out,
    input  logic        alu_overflow,
    output logic        result_valid,
    output logic [31:0] result_data,
    output logic [4:0]  result_rd,
    output logic        wb_en,
    output logic        ovf_trap,
    output logic        illegal_instr,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    state_t r_state, w_next;
    logic [5:0] r_op, r_fn;
    logic [4:0] r_rs, r_rt, r_rd;
    logic [CW-1:0] r_cnt;
    logic [31:0] w_rs_data, w_rt_data;
    logic w_legal, w_addsub, w_hold_done;
    assign w_legal     = is_legal(r_op, r_fn);
    assign w_addsub    = r_fn == FUNCT_ADD || r_fn == FUNCT_SUB;
    assign w_hold_done = r_cnt == CW'(HOLD_CYCLES - 1);
    assign instr_ready = rst_n && r_state == ST_IDLE;
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = instr_valid ? ST_READ : ST_IDLE;
            ST_READ: w_next = w_legal ? ST_HOLD : ST_WB;
            ST_HOLD: w_next = w_hold_done ? ST_WB : ST_HOLD;
            default: w_next = ST_IDLE;
        endcase
    end
    // Result and flags register on the edge entering WB; the regfile write follows on the WB edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {r_op, r_fn, r_rs, r_rt, r_rd} <= '0;
            r_cnt         <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_funct     <= '0;
            result_data   <= '0;
            result_rd     <= '0;
            result_valid  <= 1'b0;
            wb_en         <= 1'b0;
            ovf_trap      <= 1'b0;
            illegal_instr <= 1'b0;
        end else begin
            result_valid  <= 1'b0;
            wb_en         <= 1'b0;
            ovf_trap      <= 1'b0;
            illegal_instr <= 1'b0;
            r_cnt         <= (r_state == ST_HOLD) ? r_cnt + 1'b1 : '0;
            if (r_state == ST_IDLE && instr_valid) begin
                r_op <= instr[OP_LSB +: 6];
                r_rs <= instr[RS_LSB +: 5];
                r_rt <= instr[RT_LSB +: 5];
                r_rd <= instr[RD_LSB +: 5];
                r_fn <= instr[FN_LSB +: 6];
            end
            if (r_state == ST_READ && w_legal) begin
                alu_a     <= w_rs_data;
                alu_b     <= w_rt_data;
                alu_funct <= r_fn;
            end
            if (r_state != ST_WB && w_next == ST_WB) begin
                result_valid  <= 1'b1;
                result_rd     <= r_rd;
                result_data   <= w_legal ? alu_out : '0;
                illegal_instr <= !w_legal;
                ovf_trap      <= w_legal && w_addsub && alu_overflow;
                wb_en         <= w_legal && r_rd != 5'd0 && !(w_addsub && alu_overflow);
            end
        end
    end
    regfile_2r1w u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (r_state == ST_WB && wb_en),
        .i_waddr (result_rd),
        .i_wdata (result_data),
        .i_ra    (r_rs),
        .i_rb    (r_rt),
        .i_rdbg  (dbg_addr),
        .o_a     (w_rs_data),
        .o_b     (w_rt_data),
        .o_dbg   (dbg_data)
    );
endmodule

// File: tb/tb_rtype_issue_wb.sv
// tb_rtype_issue_wb: directed vectors against a registered ALU stand-in that can
// inject a result (to preload registers) or force overflow.
module tb_rtype_issue_wb;
    import mips_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [5:0]  alu_funct;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        alu_overflow;
    logic        result_valid, wb_en, ovf_trap, illegal_instr;
    logic [31:0] result_data;
    logic [4:0]  result_rd;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic        inj_en = 1'b0, force_ovf = 1'b0;
    logic [31:0] inj_val = '0, alu_f;
    int n_checks = 0, n_errors = 0;
    int lat;
    logic [31:0] c_data, h_a, h_b;
    logic [4:0]  c_rd;
    logic        c_wb, c_ovf, c_ill;
    rtype_issue_wb #(.HOLD_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_overflow(alu_overflow), .result_valid(result_valid),
        .result_data(result_data), .result_rd(result_rd), .wb_en(wb_en),
        .ovf_trap(ovf_trap), .illegal_instr(illegal_instr),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );
    always #5 clk = ~clk;
    always_comb begin
        alu_f = '0;
        case (alu_funct)
            FUNCT_ADD: alu_f = alu_a + alu_b;
            FUNCT_SUB: alu_f = alu_a - alu_b;
            FUNCT_AND: alu_f = alu_a & alu_b;
            FUNCT_OR:  alu_f = alu_a | alu_b;
            FUNCT_SLT: alu_f = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default:   alu_f = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        alu_out      <= inj_en ? inj_val : alu_f;
        alu_overflow <= force_ovf;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [5:0] fn);
        return {op, rs, rt, rd, 5'd0, fn};
    endfunction
    task automatic wait_ready();
        @(negedge clk);
        for (int i = 0; i < 20 && !instr_ready; i++) @(negedge clk);
    endtask
    task automatic run(input logic [31:0] w);
        wait_ready();
        instr = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr = 32'hFFFF_FFFF;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 2) instr_valid = 1'b0;
            if (lat == 3) begin h_a = alu_a; h_b = alu_b; end
        end while (!result_valid && lat < 20);
        instr_valid = 1'b0;
        c_data = result_data; c_rd = result_rd;
        c_wb = wb_en; c_ovf = ovf_trap; c_ill = illegal_instr;
    endtask
    task automatic peek(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        dbg_addr = a;
        #1 d = dbg_data;
    endtask
    task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
        inj_en = 1'b1; inj_val = v;
        run(enc(OPCODE_RTYPE, 5'd0, 5'd0, r, FUNCT_OR));
        inj_en = 1'b0;
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [31:0] d;
        logic        seen;
        int          acc [3];
        int          n;
        repeat (2) @(posedge clk);
        #1 chk("ready_in_reset", {31'd0, instr_ready}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, instr_ready}, 32'd1);
        chk("flags_after_reset", {28'd0, result_valid, wb_en, ovf_trap, illegal_instr}, 32'd0);
        chk("alu_a_reset", alu_a, 32'd0);
        chk("result_data_reset", result_data, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1 if (dbg_data !== 32'd0) seen = 1'b1;
        end
        chk("rf_all_zero", {31'd0, seen}, 32'd0);
        set_reg(5'd1, 32'd5);
        set_reg(5'd2, 32'd7);
        run(enc(OPCODE_RTYPE, 5'd1, 5'd2, 5'd3, FUNCT_ADD));
        chk("add_latency", lat, 32'd5);
        chk("add_hold_a", h_a, 32'd5);
        chk("add_hold_b", h_b, 32'd7);
        chk("add_data", c_data, 32'd12);
        chk("add_rd", {27'd0, c_rd}, 32'd3);
        chk("add_flags", {29'd0, c_wb, c_ovf, c_ill}, 32'b100);
        @(negedge clk);
        chk("add_valid_pulse", {31'd0, result_valid}, 32'd0);
        peek(5'd3, d); chk("add_dbg_r3", d, 32'd12);
        set_reg(5'd1, 32'h0000_00F0);
        set_reg(5'd2, 32'h0000_000F);
        run(enc(OPCODE_RTYPE, 5'd1, 5'd2, 5'd0, FUNCT_OR));
        chk("or_r0_data", c_data, 32'h0000_00FF);
        chk("or_r0_wb", {31'd0, c_wb}, 32'd0);
        peek(5'd0, d); chk("or_r0_dbg", d, 32'd0);
        run(32'h0000_0000);
        chk("nop_latency", lat, 32'd2);
        chk("nop_flags", {29'd0, c_wb, c_ovf, c_ill}, 32'b001);
        chk("nop_data", c_data, 32'd0);
        run(enc(6'h08, 5'd1, 5'd2, 5'd5, FUNCT_ADD));
        chk("opc8_latency", lat, 32'd2);
        chk("opc8_flags", {29'd0, c_wb, c_ovf, c_ill}, 32'b001);
        chk("opc8_rd", {27'd0, c_rd}, 32'd5);
        peek(5'd5, d); chk("opc8_dbg_r5", d, 32'd0);
        force_ovf = 1'b1;
        run(enc(OPCODE_RTYPE, 5'd1, 5'd2, 5'd4, FUNCT_ADD));
        chk("ovf_add_flags", {29'd0, c_wb, c_ovf, c_ill}, 32'b010);
        peek(5'd4, d); chk("ovf_add_dbg_r4", d, 32'd0);
        run(enc(OPCODE_RTYPE, 5'd1, 5'd2, 5'd5, FUNCT_SUB));
        chk("ovf_sub_flags", {29'd0, c_wb, c_ovf, c_ill}, 32'b010);
        run(enc(OPCODE_RTYPE, 5'd2, 5'd1, 5'd6, FUNCT_SLT));
        chk("slt_ovf_ignored_flags", {29'd0, c_wb, c_ovf, c_ill}, 32'b100);
        chk("slt_data", c_data, 32'd1);
        peek(5'd6, d); chk("slt_dbg_r6", d, 32'd1);
        force_ovf = 1'b0;
        wait_ready();
        instr = enc(OPCODE_RTYPE, 5'd1, 5'd2, 5'd7, FUNCT_OR);
        instr_valid = 1'b1;
        acc = '{-100, -100, -100};
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (instr_ready && n < 3) begin acc[n] = c; n++; end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("b2b_gap1", acc[1] - acc[0], 32'd6);
        chk("b2b_gap2", acc[2] - acc[1], 32'd6);
        wait_ready();
        peek(5'd7, d); chk("b2b_dbg_r7", d, 32'h0000_00FF);
        wait_ready();
        instr = enc(OPCODE_RTYPE, 5'd1, 5'd2, 5'd8, FUNCT_ADD);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 chk("abort_ready_low", {31'd0, instr_ready}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (result_valid) seen = 1'b1;
        end
        chk("abort_no_valid", {31'd0, seen}, 32'd0);
        peek(5'd8, d); chk("abort_dbg_r8", d, 32'd0);
        chk("abort_ready_back", {31'd0, instr_ready}, 32'd1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
